div_issue_ctrl: RTL and testbench

Sequential front-end for the 16-bit combinational divider.
- Accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a 2-entry FIFO.
- Drives the head pair onto the divider's a/b inputs and holds them stable for a fixed settle window, since the gate-level divider has long ripple paths.
- Captures the quotient into an output register with its own valid/ready handshake for downstream consumers.

---
 rtl/div_issue_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequential front-end for a combinational divider.
// Operand pairs are buffered in a 2-entry FIFO and driven onto the divider
// inputs. The inputs are held for SETTLE cycles before the quotient is
// registered behind a valid/ready output handshake.
// Optional feature: define DIV_DBZ_EN so that divide-by-zero pairs skip the
// settle window and return an all-ones quotient with out_dbz set.
module div_issue_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_dbz
);

`ifdef DIV_DBZ_EN
  localparam bit DbzEn = 1'b1;
`else
  localparam bit DbzEn = 1'b0;
`endif

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHold
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] fifoMem_q [2];
  logic               wrPtr_q, rdPtr_q;
  logic [1:0]         count_q;
  logic [WIDTH-1:0]   divA_q, divA_d;
  logic [WIDTH-1:0]   divB_q, divB_d;
  logic [WIDTH-1:0]   outQ_q, outQ_d;
  logic               outDbz_q, outDbz_d;
  logic               outValid_q, outValid_d;
  logic               dbzPend_q, dbzPend_d;

  logic               push;
  logic               pop;
  logic               capture;
  logic               canCapture;
  logic [WIDTH-1:0]   headA;
  logic [WIDTH-1:0]   headB;

  assign in_ready   = (count_q != 2'd2);
  assign push       = in_valid && in_ready;
  assign canCapture = !outValid_q || out_ready;
  assign headA      = fifoMem_q[rdPtr_q][2*WIDTH-1:WIDTH];
  assign headB      = fifoMem_q[rdPtr_q][WIDTH-1:0];

  assign div_a     = divA_q;
  assign div_b     = divB_q;
  assign out_q     = outQ_q;
  assign out_valid = outValid_q;
  assign out_dbz   = outDbz_q;

  // Operand FIFO: pop always reads the older slot, so a push and a pop in
  // the same cycle never collide on the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifoMem_q[i] <= '0;
      end
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        fifoMem_q[wrPtr_q] <= {in_a, in_b};
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue FSM: load operands from IDLE, wait out the settle window, then
  // capture the quotient once the output register is free.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    divA_d     = divA_q;
    divB_d     = divB_q;
    outQ_d     = outQ_q;
    outDbz_d   = outDbz_q;
    outValid_d = outValid_q && !out_ready;
    dbzPend_d  = dbzPend_q;
    pop        = 1'b0;
    capture    = 1'b0;

    case (state_q)
      StIdle: begin
        if (count_q != 2'd0) begin
          pop    = 1'b1;
          divA_d = headA;
          divB_d = headB;
          cnt_d  = 4'd0;
          if (DbzEn && (headB == '0)) begin
            dbzPend_d = 1'b1;
            state_d   = StHold;
          end else begin
            dbzPend_d = 1'b0;
            state_d   = StSettle;
          end
        end
      end
      StSettle: begin
        if (cnt_q == SettleLast) begin
          if (canCapture) begin
            capture = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHold: begin
        if (canCapture) begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (capture) begin
      outValid_d = 1'b1;
      outQ_d     = dbzPend_q ? {WIDTH{1'b1}} : div_q;
      outDbz_d   = dbzPend_q;
      dbzPend_d  = 1'b0;
    end
  end

  // State, divider operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      divA_q     <= '0;
      divB_q     <= '0;
      outQ_q     <= '0;
      outDbz_q   <= 1'b0;
      outValid_q <= 1'b0;
      dbzPend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      divA_q     <= divA_d;
      divB_q     <= divB_d;
      outQ_q     <= outQ_d;
      outDbz_q   <= outDbz_d;
      outValid_q <= outValid_d;
      dbzPend_q  <= dbzPend_d;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Testbench for div_issue_ctrl: a behavioural divider feeds div_q, a queue
// holds expected results and a negedge monitor checks every output transfer.
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] div_a;
  logic [15:0] div_b;
  logic [15:0] div_q;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_q;
  logic        out_dbz;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];

  logic        heldV = 1'b0;
  logic [15:0] heldQ = '0;
  logic        stopToggle;

  div_issue_ctrl #(.WIDTH(16), .SETTLE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_q    (div_q),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q    (out_q),
    .out_dbz  (out_dbz)
  );

  // Behavioural stand-in for the combinational divider.
  assign div_q = (div_b == 16'd0) ? 16'hFFFF : (div_a / div_b);

  // 100 MHz-style free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push one pair, waiting (bounded) for in_ready; expected result is queued on transfer.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] expQ, input logic expDbz);
    int  n = 0;
    bit  done = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!done && n < 60) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (done) begin
      sb.push_back({expDbz, expQ});
    end else begin
      checkOutput("push_timeout", 32'd0, 32'd1);
    end
  endtask

  // Count cycles from the push edge to out_valid, checking operands stay stable.
  task automatic measureLatency(input int expLat, input logic [15:0] expA, input logic [15:0] expB);
    int n = 0;
    bit seen = 0;
    while (!seen && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
      end else begin
        checkOutput("settle_div_a", 32'(div_a), 32'(expA));
        checkOutput("settle_div_b", 32'(div_b), 32'(expB));
      end
    end
    checkOutput("latency", n, expLat);
  endtask

  // Wait (bounded) until every queued expectation has been consumed.
  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (sb.size() != 0 && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_left", sb.size(), 0);
  endtask

  // Monitor: checks held-result stability and compares each transfer against the queue.
  always @(negedge clk) begin
    if (rst) begin
      heldV = 1'b0;
    end else begin
      if (heldV) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_q", 32'(out_q), 32'(heldQ));
      end
      heldV = out_valid && !out_ready;
      heldQ = out_q;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 32'(out_q), 32'hDEAD);
        end else begin
          logic [16:0] e;
          e = sb.pop_front();
          checkOutput("result_q", 32'(out_q), 32'(e[15:0]));
          checkOutput("result_dbz", 32'(out_dbz), 32'(e[16]));
        end
      end
    end
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    stopToggle = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_q", 32'(out_q), 32'd0);
    checkOutput("rst_div_a", 32'(div_a), 32'd0);
    checkOutput("rst_div_b", 32'(div_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pair 5/3: latency 1+SETTLE, operands stable during settle
    applyStimulus(16'd5, 16'd3, 16'd1, 1'b0);
    measureLatency(5, 16'd5, 16'd3);
    waitDrain(40);

    // Back-to-back pushes fill the FIFO
    applyStimulus(16'd100, 16'd7, 16'd14, 1'b0);
    applyStimulus(16'd65535, 16'd255, 16'd257, 1'b0);
    applyStimulus(16'd9, 16'd10, 16'd0, 1'b0);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    waitDrain(80);

    // Blocked output: first result held, second pair parked in HOLD
    out_ready = 1'b0;
    applyStimulus(16'd20, 16'd4, 16'd5, 1'b0);
    applyStimulus(16'd30, 16'd5, 16'd6, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("blocked_valid", 32'(out_valid), 32'd1);
    checkOutput("blocked_q", 32'(out_q), 32'd5);
    checkOutput("hold_div_a", 32'(div_a), 32'd30);
    checkOutput("hold_div_b", 32'(div_b), 32'd5);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitDrain(40);

    // Asynchronous reset in the middle of the settle window
    applyStimulus(16'd50, 16'd2, 16'd25, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    checkOutput("midrst_div_a", 32'(div_a), 32'd0);
    checkOutput("midrst_div_b", 32'(div_b), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_q", 32'(out_q), 32'd0);
    checkOutput("midrst_out_dbz", 32'(out_dbz), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checkOutput("postrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;

    // Divide by zero
`ifdef DIV_DBZ_EN
    applyStimulus(16'd123, 16'd0, 16'hFFFF, 1'b1);
    measureLatency(2, 16'd123, 16'd0);
`else
    applyStimulus(16'd123, 16'd0, 16'hFFFF, 1'b0);
    measureLatency(5, 16'd123, 16'd0);
`endif
    waitDrain(40);

    // Twenty pairs streamed while the consumer randomly stalls
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          ra = 16'($urandom_range(0, 65535));
          rb = 16'($urandom_range(1, 300));
          applyStimulus(ra, rb, ra / rb, 1'b0);
        end
        stopToggle = 1'b1;
      end
      begin
        while (!stopToggle) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    waitDrain(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
